// File: rtl/debouncer_pkg.sv
// Timing helpers and per-key event type shared by the key debouncer.
// Build option: define DEBOUNCER_LONG_PRESS_EN to add per-channel long-press detection.
package debouncer_pkg;

`ifdef DEBOUNCER_LONG_PRESS_EN
   localparam bit LONG_PRESS_EN = 1'b1;
`else
   localparam bit LONG_PRESS_EN = 1'b0;
`endif

   typedef struct packed {
      logic pressed;
      logic released;
      logic long_press;
   } key_evt_t;

   // Stable-sample count needed before a level change is accepted; at least one.
   function automatic int glitch_cycles(input int freq_mhz, input int time_ns);
      int g;
      g = (freq_mhz * time_ns + 999) / 1000;
      return (g < 1) ? 1 : g;
   endfunction

   function automatic int long_cycles(input int freq_mhz, input int time_us);
      return freq_mhz * time_us;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One key: 2-FF synchroniser, glitch filter, press/release strobes and, when
// DEBOUNCER_LONG_PRESS_EN is defined, a saturating hold counter for the long-press strobe.
module debounce_channel
   import debouncer_pkg::*;
#(
   parameter int G              = 15,
   parameter int L              = 150,
   parameter bit KEY_ACTIVE_LOW = 1'b0
) (
   input  logic     clk_i,
   input  logic     srst_i,
   input  logic     key_i,
   output logic     key_state_o,
   output key_evt_t evt_o
);

   localparam int            CW     = $clog2(G + 1);
   localparam logic [CW-1:0] G_LAST = CW'(G - 1);

   logic [1:0]    sync_q;
   logic          key_sync;
   logic [CW-1:0] cnt_q;
   logic          state_q;
   logic          press_q;
   logic          release_q;
   logic          long_q;

   assign key_sync = sync_q[1] ^ KEY_ACTIVE_LOW;

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         sync_q    <= {2{KEY_ACTIVE_LOW}};
         cnt_q     <= '0;
         state_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], key_i};
         press_q   <= 1'b0;
         release_q <= 1'b0;
         if (key_sync == state_q) begin
            cnt_q <= '0;
         end else if (cnt_q == G_LAST) begin
            cnt_q     <= '0;
            state_q   <= key_sync;
            press_q   <= key_sync;
            release_q <= ~key_sync;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   if (LONG_PRESS_EN && L > 0) begin : g_long
      localparam int            LW     = $clog2(L + 1);
      localparam logic [LW-1:0] L_LAST = LW'(L - 1);
      localparam logic [LW-1:0] L_MAX  = LW'(L);
      logic [LW-1:0] hold_q;

      // Saturating at L leaves exactly one pulse per press; a release re-arms it.
      always_ff @(posedge clk_i) begin
         if (srst_i || !state_q) begin
            hold_q <= '0;
            long_q <= 1'b0;
         end else begin
            long_q <= (hold_q == L_LAST);
            if (hold_q != L_MAX) hold_q <= hold_q + 1'b1;
         end
      end
   end else begin : g_nolong
      assign long_q = 1'b0;
   end

   assign key_state_o = state_q;
   assign evt_o       = '{pressed: press_q, released: release_q, long_press: long_q};

endmodule

// File: rtl/multi_key_debouncer.sv
// N independent key debouncers; long-press strobes exist only with DEBOUNCER_LONG_PRESS_EN.
module multi_key_debouncer
   import debouncer_pkg::*;
#(
   parameter int CHANNELS       = 4,
   parameter int CLK_FREQ_MHZ   = 150,
   parameter int GLITCH_TIME_NS = 100,
   parameter bit KEY_ACTIVE_LOW = 1'b0,
   parameter int LONG_PRESS_US  = 500000
) (
   input  logic                clk_i,
   input  logic                srst_i,
   input  logic [CHANNELS-1:0] key_i,
   output logic [CHANNELS-1:0] key_state_o,
   output logic [CHANNELS-1:0] key_pressed_stb_o,
   output logic [CHANNELS-1:0] key_released_stb_o,
   output logic [CHANNELS-1:0] key_long_stb_o
);

   localparam int G = glitch_cycles(CLK_FREQ_MHZ, GLITCH_TIME_NS);
   localparam int L = long_cycles(CLK_FREQ_MHZ, LONG_PRESS_US);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      key_evt_t evt;

      debounce_channel #(
         .G              (G),
         .L              (L),
         .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
      ) u_ch (
         .clk_i       (clk_i),
         .srst_i      (srst_i),
         .key_i       (key_i[c]),
         .key_state_o (key_state_o[c]),
         .evt_o       (evt)
      );

      assign key_pressed_stb_o[c]  = evt.pressed;
      assign key_released_stb_o[c] = evt.released;
      assign key_long_stb_o[c]     = evt.long_press;
   end

endmodule
